// File: rtl/load_seq_pkg.sv
// Shared types and default sizing for the load sequencer slice.
package load_seq_pkg;

  localparam int DEF_DATA_W = 10;
  localparam int DEF_DEPTH  = 8;
  localparam int DEF_GAP_W  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    WAIT = 2'd2
  } state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy; DEPTH must be a power of two so
// the pointers wrap for free.
module sync_fifo #(
  parameter int DATA_W = 10,
  parameter int DEPTH  = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  count
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic              do_push, do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // NOTE: sequential state is written with <= so every flop samples the
  // pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; empty/count gate every read, so
  // clearing it would only cost a reset net on every bit.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/load_sequencer.sv
// Drains queued words into load_counter as one-cycle load strobes, spaced by a
// programmable idle gap between loads.
module load_sequencer
  import load_seq_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int GAP_W  = DEF_GAP_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [DATA_W-1:0]        in_data,
  output logic                     in_ready,
  input  logic                     enable,
  input  logic [GAP_W-1:0]         gap,
  output logic                     load_en,
  output logic [DATA_W-1:0]        data_out,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     busy
);

  state_e            state_q, state_d;
  logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
  logic              load_en_q;
  logic [DATA_W-1:0] data_out_q;
  logic [DATA_W-1:0] fifo_head;
  logic              fifo_full, fifo_empty;

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (in_valid && in_ready),
    .pop   (state_q == LOAD),
    .wdata (in_data),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // NOTE: every signal driven here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    gap_cnt_d = gap_cnt_q;
    unique case (state_q)
      IDLE: if (enable && !fifo_empty) state_d = LOAD;
      LOAD: begin
        state_d   = WAIT;
        gap_cnt_d = gap;
      end
      WAIT: begin
        if (gap_cnt_q == '0) state_d = IDLE;
        else                 gap_cnt_d = gap_cnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Strobe and data are registered off the next state so they line up with
  // LOAD without any combinational path from the upstream handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      gap_cnt_q  <= '0;
      load_en_q  <= 1'b0;
      data_out_q <= '0;
    end else begin
      state_q   <= state_d;
      gap_cnt_q <= gap_cnt_d;
      load_en_q <= (state_d == LOAD);
      if (state_d == LOAD) data_out_q <= fifo_head;
    end
  end

  assign in_ready = !fifo_full;
  assign load_en  = load_en_q;
  assign data_out = data_out_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_load_sequencer.sv
// Bench for load_sequencer: directed scenarios plus randomized traffic checked
// against a timeline model (queue of words + time of the last load).
module tb_load_sequencer;

  localparam int DATA_W = 10;
  localparam int DEPTH  = 8;
  localparam int GAP_W  = 8;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              reset, in_valid, enable;
  logic [DATA_W-1:0] in_data;
  logic [GAP_W-1:0]  gap;
  logic              in_ready, load_en, busy;
  logic [DATA_W-1:0] data_out;
  logic [CNT_W-1:0]  fifo_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  load_sequencer #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .GAP_W  (GAP_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .enable     (enable),
    .gap        (gap),
    .load_en    (load_en),
    .data_out   (data_out),
    .fifo_count (fifo_count),
    .busy       (busy)
  );

  // Model: a load may start in the cycle after an idle cycle that saw enable
  // and a non-empty queue; after a load at cycle L with gap G the block is
  // idle again from cycle L+G+2 on.
  logic [DATA_W-1:0] mq[$];
  logic [DATA_W-1:0] got_q[$];
  int                cyc       = 0;
  bit                have_load = 0;
  int                last_load = 0;
  int                last_gap  = 0;
  bit                exp_load_en = 0;
  bit                exp_busy    = 0;
  logic [DATA_W-1:0] exp_data    = '0;

  task automatic tick();
    @(posedge clk);
    if (reset) begin
      mq.delete();
      have_load   = 0;
      exp_load_en = 0;
      exp_data    = '0;
    end else begin
      int                sz       = mq.size();
      bit                idle_now = !have_load || (cyc >= last_load + last_gap + 2);
      bit                start    = idle_now && enable && (sz != 0);
      logic [DATA_W-1:0] head     = '0;
      if (sz != 0) head = mq[0];
      if (exp_load_en) begin
        last_gap = int'(gap);
        void'(mq.pop_front());
      end
      if (in_valid && sz != DEPTH) mq.push_back(in_data);
      exp_load_en = start;
      if (start) begin
        exp_data  = head;
        have_load = 1;
        last_load = cyc + 1;
      end
    end
    cyc++;
    exp_busy = exp_load_en ||
               (have_load && cyc > last_load && cyc < last_load + last_gap + 2);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    tick();
    reset    = 1'b0;
  endtask

  task automatic wait_load(input int budget, output bit found);
    found = 0;
    for (int i = 0; i < budget && !found; i++) begin
      if (load_en) found = 1;
      else tick();
    end
  endtask

  task automatic collect(input int n, input int budget);
    got_q.delete();
    for (int i = 0; i < budget && got_q.size() < n; i++) begin
      tick();
      if (load_en) got_q.push_back(data_out);
    end
  endtask

  task automatic push_words(input logic [DATA_W-1:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = base + DATA_W'(i);
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; in_data = '0; enable = 1'b0; gap = '0;
    tick(); tick();
    reset = 1'b0;
    checks++; if (load_en !== 1'b0) begin errors++; $display("FAIL reset_load_en: got %0b want 0", load_en); end
    checks++; if (data_out !== '0) begin errors++; $display("FAIL reset_data_out: got %h want 000", data_out); end
    checks++; if (fifo_count !== '0) begin errors++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", busy); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
  endtask

  task automatic test_latency();
    do_reset();
    gap = '0; enable = 1'b1;
    in_valid = 1'b1; in_data = 10'h2A5;
    tick();
    in_valid = 1'b0;
    checks++; if (load_en !== 1'b0) begin errors++; $display("FAIL lat_early: got %0b want 0", load_en); end
    tick();
    checks++; if (load_en !== 1'b1) begin errors++; $display("FAIL lat_strobe: got %0b want 1", load_en); end
    checks++; if (data_out !== 10'h2A5) begin errors++; $display("FAIL lat_data: got %h want 2a5", data_out); end
    tick();
    checks++; if (load_en !== 1'b0) begin errors++; $display("FAIL lat_one_cycle: got %0b want 0", load_en); end
    checks++; if (data_out !== 10'h2A5) begin errors++; $display("FAIL lat_hold: got %h want 2a5", data_out); end
    checks++; if (fifo_count !== '0) begin errors++; $display("FAIL lat_count: got %0d want 0", fifo_count); end
  endtask

  task automatic test_back_to_back();
    int t[$];
    int v[$];
    do_reset();
    gap = 8'd4; enable = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      in_valid = (k <= 3);
      in_data  = DATA_W'(k);
      tick();
      if (load_en) begin t.push_back(k); v.push_back(int'(data_out)); end
    end
    in_valid = 1'b0;
    checks++;
    if (t.size() != 3) begin
      errors++; $display("FAIL b2b_pulses: got %0d want 3", t.size());
    end else begin
      checks++; if (t[0] != 2) begin errors++; $display("FAIL b2b_first: got %0d want 2", t[0]); end
      checks++; if (t[1] - t[0] != 7 || t[2] - t[1] != 7) begin
        errors++; $display("FAIL b2b_spacing: got %0d,%0d want 7,7", t[1] - t[0], t[2] - t[1]);
      end
      checks++; if (v[0] != 1 || v[1] != 2 || v[2] != 3) begin
        errors++; $display("FAIL b2b_order: got %0d,%0d,%0d want 1,2,3", v[0], v[1], v[2]);
      end
    end
  endtask

  task automatic test_full();
    do_reset();
    enable = 1'b0; gap = '0;
    for (int i = 0; i < 9; i++) begin
      if (i == 8) begin
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %0b want 0", in_ready); end
        checks++; if (fifo_count !== 4'd8) begin errors++; $display("FAIL full_count8: got %0d want 8", fifo_count); end
      end
      in_valid = 1'b1; in_data = 10'h100 + DATA_W'(i);
      tick();
    end
    in_valid = 1'b0;
    checks++; if (fifo_count !== 4'd8) begin errors++; $display("FAIL full_held_off: got %0d want 8", fifo_count); end
    enable = 1'b1;
    collect(8, 100);
    checks++;
    if (got_q.size() != 8) begin
      errors++; $display("FAIL full_drain_n: got %0d want 8", got_q.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (got_q[i] !== 10'h100 + DATA_W'(i)) begin
          errors++; $display("FAIL full_drain_word%0d: got %h want %h", i, got_q[i], 10'h100 + DATA_W'(i));
        end
      end
    end
    collect(1, 20);
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL full_ninth: got %0d extra loads want 0", got_q.size()); end
  endtask

  task automatic test_push_pop();
    bit found;
    do_reset();
    enable = 1'b0; gap = 8'd1;
    push_words(10'h200, 4);
    enable = 1'b1;
    wait_load(10, found);
    checks++; if (!found) begin errors++; $display("FAIL pp_no_load: got none want load_en"); end
    checks++; if (data_out !== 10'h200) begin errors++; $display("FAIL pp_first: got %h want 200", data_out); end
    checks++; if (fifo_count !== 4'd4) begin errors++; $display("FAIL pp_count_pre: got %0d want 4", fifo_count); end
    in_valid = 1'b1; in_data = 10'h2FF; enable = 1'b0;
    tick();
    in_valid = 1'b0;
    checks++; if (fifo_count !== 4'd4) begin errors++; $display("FAIL pp_count_post: got %0d want 4", fifo_count); end
    repeat (10) tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL pp_idle: got %0b want 0", busy); end
    enable = 1'b1;
    collect(4, 50);
    checks++;
    if (got_q.size() != 4) begin
      errors++; $display("FAIL pp_drain_n: got %0d want 4", got_q.size());
    end else begin
      checks++;
      if (got_q[0] !== 10'h201 || got_q[1] !== 10'h202 || got_q[2] !== 10'h203 || got_q[3] !== 10'h2FF) begin
        errors++; $display("FAIL pp_order: got %h %h %h %h want 201 202 203 2ff", got_q[0], got_q[1], got_q[2], got_q[3]);
      end
    end
  endtask

  task automatic test_enable_drop();
    bit found;
    int pulses = 0;
    do_reset();
    enable = 1'b0; gap = 8'd3;
    push_words(10'h0A0, 3);
    enable = 1'b1;
    wait_load(10, found);
    checks++; if (!found || data_out !== 10'h0A0) begin errors++; $display("FAIL drop_first: got %h want 0a0", data_out); end
    tick();
    enable = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL drop_in_wait: got busy %0b want 1", busy); end
    for (int i = 0; i < 12; i++) begin
      tick();
      if (load_en) pulses++;
    end
    checks++; if (pulses != 0) begin errors++; $display("FAIL drop_held: got %0d loads want 0", pulses); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL drop_idle: got busy %0b want 0", busy); end
    checks++; if (fifo_count !== 4'd2) begin errors++; $display("FAIL drop_count: got %0d want 2", fifo_count); end
    enable = 1'b1;
    tick();
    checks++; if (load_en !== 1'b1 || data_out !== 10'h0A1) begin
      errors++; $display("FAIL drop_resume: got load_en %0b data %h want 1 0a1", load_en, data_out);
    end
  endtask

  task automatic test_reset_mid_wait();
    bit found;
    do_reset();
    enable = 1'b0; gap = 8'd5;
    push_words(10'h3A0, 3);
    enable = 1'b1;
    wait_load(10, found);
    checks++; if (!found) begin errors++; $display("FAIL rst_no_load: got none want load_en"); end
    tick(); tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_in_wait: got busy %0b want 1", busy); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (fifo_count !== '0) begin errors++; $display("FAIL rst_mid_count: got %0d want 0", fifo_count); end
    checks++; if (load_en !== 1'b0) begin errors++; $display("FAIL rst_mid_load_en: got %0b want 0", load_en); end
    checks++; if (data_out !== '0) begin errors++; $display("FAIL rst_mid_data: got %h want 000", data_out); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready: got %0b want 1", in_ready); end
    tick();
    checks++; if (load_en !== 1'b0) begin errors++; $display("FAIL rst_after_load_en: got %0b want 0", load_en); end
  endtask

  task automatic test_random();
    int en_pct = 50;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) en_pct = ($urandom_range(2) == 0) ? 10 : (($urandom_range(1) == 0) ? 50 : 95);
      reset    = ($urandom_range(149) == 0);
      in_valid = $urandom_range(1) == 1;
      in_data  = DATA_W'($urandom);
      enable   = $urandom_range(99) < en_pct;
      gap      = GAP_W'($urandom_range(5));
      tick();
      checks++; if (load_en !== exp_load_en) begin errors++; $display("FAIL rnd_load_en @%0d: got %0b want %0b", cyc, load_en, exp_load_en); end
      checks++; if (data_out !== exp_data) begin errors++; $display("FAIL rnd_data @%0d: got %h want %h", cyc, data_out, exp_data); end
      checks++; if (fifo_count !== CNT_W'(mq.size())) begin errors++; $display("FAIL rnd_count @%0d: got %0d want %0d", cyc, fifo_count, mq.size()); end
      checks++; if (busy !== exp_busy) begin errors++; $display("FAIL rnd_busy @%0d: got %0b want %0b", cyc, busy, exp_busy); end
      checks++; if (in_ready !== (mq.size() != DEPTH)) begin errors++; $display("FAIL rnd_ready @%0d: got %0b want %0b", cyc, in_ready, mq.size() != DEPTH); end
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = '0; enable = 1'b0; gap = '0;
    @(negedge clk);
    test_reset();
    test_latency();
    test_back_to_back();
    test_full();
    test_push_pop();
    test_enable_drop();
    test_reset_mid_wait();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/load_sequencer.md
LOAD_SEQUENCER -- requirements
Module: load_sequencer

Interface
REQ-001 Parameter DATA_W, default 10, SHALL set the data word width, matching the load_counter data_in width.
REQ-002 Parameter DEPTH, default 8, SHALL set the FIFO depth in words; it SHALL be a power of two.
REQ-003 Parameter GAP_W, default 8, SHALL set the width of the inter-load gap control.
REQ-004 Port clk, input, 1 bit: the only clock; all logic SHALL be rising-edge.
REQ-005 Port reset, input, 1 bit: the reset; it SHALL be synchronous and active-high.
REQ-006 Port in_valid, input, 1 bit: the upstream word is valid.
REQ-007 Port in_data, input, DATA_W bits: the upstream word.
REQ-008 Port in_ready, output, 1 bit: the FIFO can accept a word this cycle.
REQ-009 Port enable, input, 1 bit: permits new loads to be issued.
REQ-010 Port gap, input, GAP_W bits: idle spacing control between loads.
REQ-011 Port load_en, output, 1 bit: one-cycle load strobe to load_counter.
REQ-012 Port data_out, output, DATA_W bits: the load value, driven to load_counter data_in.
REQ-013 Port fifo_count, output, $clog2(DEPTH)+1 bits: the FIFO occupancy, range 0..DEPTH.
REQ-014 Port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-015 A push SHALL occur on a rising edge when in_valid and in_ready are both high; words SHALL pop in FIFO order.
REQ-016 in_ready SHALL equal (fifo_count != DEPTH), decoded from registered count only; a pop in the same cycle SHALL NOT raise in_ready.
REQ-017 FSM states SHALL be IDLE, LOAD and WAIT.
REQ-018 IDLE -> LOAD SHALL occur when enable is high and fifo_count != 0; otherwise the FSM SHALL stay in IDLE.
REQ-019 In LOAD (exactly one cycle), load_en SHALL be 1 and data_out SHALL equal the FIFO head word; the head SHALL pop at the end of that cycle.
REQ-020 LOAD -> WAIT SHALL be unconditional; the wait counter SHALL load gap as sampled in the LOAD cycle.
REQ-021 WAIT SHALL decrement the counter each cycle and go to IDLE in the cycle the counter equals 0, so WAIT lasts gap+1 cycles (1 cycle when gap = 0).
REQ-022 Minimum load_en period SHALL be gap+3 cycles: LOAD, WAIT x (gap+1), IDLE.
REQ-023 load_en SHALL be 0 in IDLE and WAIT; data_out SHALL hold the last loaded value outside LOAD.
REQ-024 Latency: a word pushed into an empty FIFO on edge N, with the FSM in IDLE and enable high, SHALL produce load_en high in the cycle after edge N+1.
REQ-025 Deasserting enable in LOAD or WAIT SHALL NOT abort the sequence; the FSM SHALL complete WAIT and then hold in IDLE.
REQ-026 A simultaneous push and pop SHALL leave fifo_count unchanged and SHALL preserve word order.
REQ-027 Pointers SHALL wrap modulo DEPTH; fifo_count SHALL never exceed DEPTH or go below 0.
REQ-028 A change of gap during WAIT SHALL NOT affect the wait in progress.

Reset
REQ-029 While reset is high at a rising edge, the FSM SHALL go to IDLE and both FIFO pointers and fifo_count SHALL clear to 0.
REQ-030 Output reset values SHALL be: load_en = 0, data_out = 0, fifo_count = 0, busy = 0, in_ready = 1.
REQ-031 Reset asserted mid-LOAD or mid-WAIT SHALL discard all queued words, and no load_en SHALL appear in the cycle after reset.

Structure
REQ-032 Package load_seq_pkg SHALL hold the state enum (IDLE, LOAD, WAIT) and the default DATA_W, DEPTH and GAP_W constants.
REQ-033 The FIFO SHALL be a sub-module sync_fifo (push, pop, full, empty, count); the FSM and gap counter SHALL live in load_sequencer.
REQ-034 load_en and data_out SHALL be registered outputs with no combinational path from in_valid.

Verification
REQ-035 Reset behaviour: push 3 words, assert reset for 1 cycle mid-WAIT -> fifo_count = 0, load_en = 0, data_out = 0, in_ready = 1.
REQ-036 Single-word latency: with enable = 1 and gap = 0, push 0x2A5 -> load_en high for one cycle, 2 cycles after the push edge, with data_out = 0x2A5.
REQ-037 Back-to-back spacing: gap = 4, push 0x001, 0x002, 0x003 -> three load_en pulses 7 cycles apart, carrying the values in order.
REQ-038 Full FIFO: enable = 0, push 9 words -> in_ready = 0 after the 8th push, the 9th word is held off, and fifo_count = 8.
REQ-039 Simultaneous push/pop: FIFO at 4 words, push in a LOAD cycle -> fifo_count stays 4 and the output order is preserved.
REQ-040 Enable drop: deassert enable during WAIT with 2 words queued -> WAIT completes, the FSM holds in IDLE, and reasserting enable issues the next load.
